// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a DEPTH-entry circular FIFO between fetch and decode
// with valid/ready on both sides, single-cycle flush, and a NOP bubble with
// pre-decoded fields presented whenever no valid entry sits at the head.
module ifid_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_pc_plus4,
    input  logic [XLEN-1:0]            in_next_pc,
    input  logic [31:0]                in_instr,
    input  logic                       in_pred_dir,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [XLEN-1:0]            out_next_pc,
    output logic [31:0]                out_instr,
    output logic                       out_pred_dir,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [2:0]                 out_funct3,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] next_pc;
        logic [31:0]     instr;
        logic            pred_dir;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    entry_t        wr_entry;
    entry_t        head_e;

    // in_ready looks only at registered occupancy so a same-cycle pop never frees a slot
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    assign wr_entry = '{pc: in_pc, pc_plus4: in_pc_plus4, next_pc: in_next_pc,
                        instr: in_instr, pred_dir: in_pred_dir};

    // Next-state for pointers and occupancy; flush empties the queue in one edge
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Control state register; reset overrides every other action
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never cleared; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[tail_q] <= wr_entry;
    end

    // Head view: stored entry when occupied, otherwise the NOP bubble
    always_comb begin
        head_e = mem_q[head_q];
        if (!out_valid) begin
            head_e = '{pc: '0, pc_plus4: '0, next_pc: '0,
                       instr: NOP_INSTR, pred_dir: 1'b0};
        end
    end

    assign out_pc       = head_e.pc;
    assign out_pc_plus4 = head_e.pc_plus4;
    assign out_next_pc  = head_e.next_pc;
    assign out_instr    = head_e.instr;
    assign out_pred_dir = head_e.pred_dir;
    assign out_opcode   = head_e.instr[6:0];
    assign out_rd       = head_e.instr[11:7];
    assign out_funct3   = head_e.instr[14:12];
    assign out_rs1      = head_e.instr[19:15];
    assign out_rs2      = head_e.instr[24:20];

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_ifid_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_pred_dir;
    logic [31:0] in_pc, in_pc_plus4, in_next_pc, in_instr;
    logic        out_valid, out_ready, out_pred_dir;
    logic [31:0] out_pc, out_pc_plus4, out_next_pc, out_instr;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifid_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_next_pc(in_next_pc),
        .in_instr(in_instr), .in_pred_dir(in_pred_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_next_pc(out_next_pc),
        .out_instr(out_instr), .out_pred_dir(out_pred_dir),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .count(count)
    );

    // Reference model: a plain queue of fetched entries
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] npc;
        logic [31:0] instr;
        logic        pd;
    } ent_t;

    ent_t mq[$];

    logic [158:0] obs_vec;
    assign obs_vec = {out_valid, in_ready, count, out_pc, out_pc_plus4, out_next_pc,
                      out_instr, out_pred_dir, out_opcode, out_rd, out_funct3,
                      out_rs1, out_rs2};

    function automatic logic [158:0] model_vec();
        ent_t e;
        logic v;
        v = (mq.size() > 0);
        if (v) e = mq[0];
        else begin
            e.pc = 0; e.pc4 = 0; e.npc = 0; e.instr = 32'h00000013; e.pd = 1'b0;
        end
        return {v, (mq.size() != DEPTH), 3'(mq.size()), e.pc, e.pc4, e.npc, e.instr,
                e.pd, e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
                e.instr[24:20]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic ordy, input logic fl, input logic rs);
        in_valid    = v;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_next_pc  = $urandom;
        in_instr    = instr;
        in_pred_dir = 1'($urandom);
        out_ready   = ordy;
        flush       = fl;
        rst         = rs;
    endtask

    // One clock: model follows the edge, then we return on the falling edge
    task automatic tick();
        ent_t e;
        bit   do_push, do_pop;
        @(posedge clk);
        if (rst) mq.delete();
        else if (flush) mq.delete();
        else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            e.pc = in_pc; e.pc4 = in_pc_plus4; e.npc = in_next_pc;
            e.instr = in_instr; e.pd = in_pred_dir;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if (obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_vec got=%h want=%h", obs_vec, model_vec());
        end
        n_chk++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL reset_ctrl got=%b%b%0d want=010", out_valid, in_ready, count);
        end
        n_chk++;
        if ({out_instr, out_pc, out_rd} !== {32'h00000013, 32'h0, 5'd0}) begin
            n_fail++; $display("FAIL reset_bubble instr=%h pc=%h rd=%0d", out_instr, out_pc, out_rd);
        end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h60 + 32'(4*i), 32'h00500093 + 32'(i << 7), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({count, in_ready, out_pc} !== {3'd4, 1'b0, 32'h60}) begin
            n_fail++; $display("FAIL fill_full count=%0d in_ready=%b pc=%h want 4/0/60", count, in_ready, out_pc);
        end
        n_chk++;
        if (obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL fill_vec got=%h want=%h", obs_vec, model_vec());
        end
        tick();
        n_chk++;
        if ({count, out_pc} !== {3'd4, 32'h60}) begin
            n_fail++; $display("FAIL stall_hold count=%0d pc=%h want 4/60", count, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({out_valid, out_pc} !== {1'b1, 32'h60 + 32'(4*i)}) begin
                n_fail++; $display("FAIL drain_order[%0d] got=%b/%h want=1/%h", i, out_valid, out_pc, 32'h60 + 32'(4*i));
            end
            tick();
        end
        n_chk++;
        if ({out_valid, out_instr} !== {1'b0, 32'h00000013}) begin
            n_fail++; $display("FAIL drain_empty valid=%b instr=%h want 0/13", out_valid, out_instr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] next_in  = 32'h1000;
        logic [31:0] next_out = 32'h1000;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, next_in, $urandom, 1'b0, 1'b0, 1'b0);
            next_in += 4;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, next_in, $urandom, 1'b1, 1'b0, 1'b0);
            n_chk++;
            if ({count, out_pc} !== {3'd2, next_out}) begin
                n_fail++; $display("FAIL wrap[%0d] count=%0d pc=%h want 2/%h", i, count, out_pc, next_out);
            end
            n_chk++;
            if (obs_vec !== model_vec()) begin
                n_fail++; $display("FAIL wrap_vec[%0d] got=%h want=%h", i, obs_vec, model_vec());
            end
            next_in  += 4;
            next_out += 4;
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_full_boundary();
        while (mq.size() < DEPTH) begin
            drive(1'b1, 32'h2000 + 32'(4*mq.size()), $urandom, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h2100, 32'h00A00113, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({count, in_ready} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL full_pre count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        tick();
        n_chk++;
        if ({count, in_ready} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL full_pop_only count=%0d in_ready=%b want 3/1", count, in_ready);
        end
        out_ready = 1'b0;
        tick();
        n_chk++;
        if (count !== 3'd4) begin
            n_fail++; $display("FAIL full_accept count=%0d want 4", count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        n_chk++;
        if ({count, out_pc, out_instr} !== {3'd1, 32'h2100, 32'h00A00113}) begin
            n_fail++; $display("FAIL full_pending_entry count=%0d pc=%h instr=%h", count, out_pc, out_instr);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h70 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h80, 32'h00100093, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if ({count, out_valid, in_ready, out_instr} !== {3'd0, 1'b0, 1'b1, 32'h00000013}) begin
            n_fail++; $display("FAIL flush count=%0d valid=%b ready=%b instr=%h", count, out_valid, in_ready, out_instr);
        end
        tick();
        n_chk++;
        if ({out_valid, out_pc} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL flush_discard valid=%b pc=%h want 0/0", out_valid, out_pc);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h90 + 32'(4*i), $urandom, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hA0, $urandom, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h60, 32'h00500093, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({count, out_valid, in_ready, out_instr, out_pc} !== {3'd0, 1'b0, 1'b1, 32'h13, 32'h0}) begin
            n_fail++; $display("FAIL rst_mid count=%0d valid=%b instr=%h pc=%h", count, out_valid, out_instr, out_pc);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if ({out_valid, out_pc, out_rd, count} !== {1'b1, 32'h60, 5'd1, 3'd1}) begin
            n_fail++; $display("FAIL rst_then_push valid=%b pc=%h rd=%0d count=%0d", out_valid, out_pc, out_rd, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0);
            tick();
            n_chk++;
            if (obs_vec !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, obs_vec, model_vec());
            end
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_fill_order();
        test_wrap();
        test_full_boundary();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- DEPTH-entry circular FIFO between fetch and decode, using valid/ready handshakes on both sides.
- Lets fetch run ahead while decode stalls. Flush squashes every buffered entry in one cycle.
- When empty or flushed, the output presents a NOP bubble (ADDI x0,x0,0) plus pre-decoded register and opcode fields for the hazard unit.

Parameters:
- XLEN, 32, width of PC and instruction fields.
- DEPTH, 4, number of entries; power of two, ≥2.
- NOP_INSTR, 32'h00000013, instruction word presented when no valid entry is at the head.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all entries (branch mispredict / redirect).
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_pc  in  XLEN  PC of fetched instruction.
- in_pc_plus4  in  XLEN  in_pc+4.
- in_next_pc  in  XLEN  predicted next PC.
- in_instr  in  32  instruction memory rdata.
- in_pred_dir  in  1  predicted branch direction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc, out_pc_plus4, out_next_pc  out  XLEN  head entry fields.
- out_instr  out  32  head instruction.
- out_pred_dir  out  1  head predicted direction.
- out_opcode  out  7  out_instr[6:0].
- out_rd  out  5  out_instr[11:7].
- out_funct3  out  3  out_instr[14:12].
- out_rs1  out  5  out_instr[19:15].
- out_rs2  out  5  out_instr[24:20].
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH entries of {pc, pc_plus4, next_pc, instr, pred_dir}. Head/tail pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 → 0. count tracks occupancy separately, so full and empty are unambiguous.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push: entry is written at tail on the clock edge; tail increments. No bypass: data pushed into an empty queue appears on the output the following cycle (latency 1).
- Pop: head increments on the clock edge.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. This is allowed at any occupancy where in_ready=1.
- Full (count==DEPTH): in_ready=0. in_ready depends only on registered count, never combinationally on out_ready, so a pop in the same cycle does not enable a push.
- Empty (count==0): out_valid=0 and the output is forced to a bubble:
  - out_instr=NOP_INSTR
  - out_pc, out_pc_plus4, out_next_pc = 0
  - out_pred_dir = 0
  - decoded fields derived from NOP_INSTR (opcode 7'h13, rd/rs1/rs2/funct3 = 0)
- Non-empty: out_* show storage[head] combinationally from registered state; out_valid=1.
- Stall: out_ready=0 holds head and all out_* stable for any number of cycles.
- Flush, highest priority after rst:
  - On the edge: head=tail=0, count=0.
  - Any same-cycle push and pop are discarded.
  - Next cycle: out_valid=0, bubble output, in_ready=1.
  - Storage contents need not be cleared.
- Reset (rst=1 at an edge), including mid-operation: head=tail=count=0. Outputs then equal the empty/bubble values above, with in_ready=1. Reset overrides flush, push and pop.
- Pushing while in_ready=0 is ignored; the queue is not corrupted. Fetch holds its request.
- Popping while empty is ignored.
- The queue adds no other state: no FSM beyond the pointers and count.

Test Plan:
- Reset then idle: rst high 2 cycles → out_valid=0, out_instr=32'h13, out_pc=0, out_rd=0, in_ready=1, count=0.
- Fill/order: push pc 0x60,0x64,0x68,0x6C with instr 0x00500093 etc. and out_ready=0 → count=4, in_ready=0, out_pc=0x60. Then out_ready=1 → pops return 0x60,0x64,0x68,0x6C in order, one per cycle; after the last pop out_valid=0.
- Wrap and concurrency: keep count=2 with push+pop every cycle for 10 cycles → count stays 2, pointers wrap past 3→0, output PCs strictly sequential with no loss or duplication.
- Full boundary: count=4 with in_valid=1, out_ready=1 → that cycle is pop only; count=3 next cycle, and the pending entry is accepted the following cycle.
- Flush mid-stream: count=3, flush=1 together with in_valid=1 (pc 0x80) → next cycle count=0, out_valid=0, out_instr=0x13, and 0x80 is not stored.
- Reset mid-operation: count=2 with rst=1 for one cycle alongside push → count=0, bubble output. The next push of pc 0x60 appears at the output exactly one cycle later.
